// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared frame states and constants for the UART stimulus transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int UART_DIV_DEFAULT = 104;
    localparam int UART_DATA_BITS   = 8;
    localparam int UART_BIT_OFFSET  = 2;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - circular byte queue with wrap-bit pointers and registered full/empty/level
module uart_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_d;
    logic [AW:0]      level_q;
    logic             full_q;
    logic             empty_q;
    logic             push;
    logic             pop;

    assign push     = s_tvalid && !full_q;
    assign pop      = m_tready && !empty_q;
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

    // pointer bookkeeping; flags come from the next pointers so they stay registered
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= wr_ptr_d - rd_ptr_d;
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        end
    end

    // storage needs no reset: clearing the pointers discards the contents
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_tdata;
        end
    end

    assign s_tready = !full_q;
    assign m_tvalid = !empty_q;
    assign m_tdata  = mem_q[rd_ptr_q[AW-1:0]];
    assign level    = level_q;

endmodule

// File: rtl/uart_tx_stim.sv
// rtl/uart_tx_stim.sv - FIFO-fed UART transmitter driving SoC ser_rx; parity bit option UART_TX_PARITY_EN
module uart_tx_stim
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_DEFAULT = UART_DIV_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          div_cfg,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic                          tx_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = DIV_WIDTH + 1;

    uart_state_e               state_q;
    logic                      ser_tx_q;
    logic [PW-1:0]             cnt_q;
    logic [PW-1:0]             period_q;
    logic [PW-1:0]             period_sel;
    logic [2:0]                bit_cnt_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] fifo_tdata;
    logic                      fifo_tvalid;
    logic                      cnt_last;
    logic                      bit_last;
    logic                      pop;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q;
`endif

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .s_tdata  (tx_data),
        .s_tvalid (tx_valid),
        .s_tready (tx_ready),
        .m_tdata  (fifo_tdata),
        .m_tvalid (fifo_tvalid),
        .m_tready (pop),
        .level    (fifo_level)
    );

    assign period_sel = (div_cfg == '0) ? PW'(DIV_DEFAULT + UART_BIT_OFFSET)
                                        : {1'b0, div_cfg} + PW'(UART_BIT_OFFSET);
    assign cnt_last   = (cnt_q == period_q - PW'(1));
    assign bit_last   = (bit_cnt_q == 3'(UART_DATA_BITS - 1));
    assign pop        = fifo_tvalid && ((state_q == IDLE) || (state_q == STOP && cnt_last));

    // frame sequencer; a pop from IDLE or the end of STOP starts the next frame on the same edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ser_tx_q  <= 1'b1;
            cnt_q     <= '0;
            period_q  <= PW'(DIV_DEFAULT + UART_BIT_OFFSET);
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (pop) begin
            state_q   <= START;
            ser_tx_q  <= 1'b0;
            cnt_q     <= '0;
            period_q  <= period_sel;
            bit_cnt_q <= '0;
            shift_q   <= fifo_tdata;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^fifo_tdata) ^ parity_odd;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                end
                START: begin
                    if (cnt_last) begin
                        cnt_q    <= '0;
                        ser_tx_q <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        state_q  <= DATA;
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_q <= '0;
                        if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                            ser_tx_q <= parity_q;
                            state_q  <= PARITY;
`else
                            ser_tx_q <= 1'b1;
                            state_q  <= STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            ser_tx_q  <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt_last) begin
                        cnt_q    <= '0;
                        ser_tx_q <= 1'b1;
                        state_q  <= STOP;
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + PW'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ser_tx_q <= 1'b1;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign ser_tx = ser_tx_q;
    assign busy   = (state_q != IDLE) || fifo_tvalid;

endmodule

// File: tb/tb_uart_tx_stim.sv
// tb/tb_uart_tx_stim.sv - directed scoreboard bench for uart_tx_stim with a line-decoding monitor
module tb_uart_tx_stim;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef struct {
        logic [7:0]  data;
        logic        start_b;
        logic        stop_b;
        logic        par_b;
        int unsigned t;
    } rx_t;

    logic        clock;
    logic        reset;
    logic [15:0] div_cfg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        ser_tx;
    logic        busy;
    logic [3:0]  fifo_level;
`ifdef UART_TX_PARITY_EN
    logic        parity_odd;
`endif

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    rx_t         rx_q[$];
    int          rx_idx = 0;
    logic [8:0]  exp_q[$];

    int          mon_active = 0;
    int          mon_cnt = 0;
    int          mon_per = 106;
    int unsigned mon_t = 0;
    logic [10:0] mon_bits = '0;

    uart_tx_stim dut (
        .clock      (clock),
        .reset      (reset),
        .div_cfg    (div_cfg),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx_ready   (tx_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // receiver: finds the falling start edge, then samples mid-bit using the divisor seen at frame start
    always @(negedge clock) begin
        if (!reset) begin
            mon_active = 0;
        end else if (mon_active == 0) begin
            if (ser_tx === 1'b0) begin
                mon_active = 1;
                mon_cnt    = 0;
                mon_per    = (div_cfg == 16'd0) ? 106 : int'(div_cfg) + 2;
                mon_t      = cyc;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt >= mon_per / 2 && (mon_cnt - mon_per / 2) % mon_per == 0) begin
                mon_bits[(mon_cnt - mon_per / 2) / mon_per] = ser_tx;
                if ((mon_cnt - mon_per / 2) / mon_per == FB - 1) begin
                    rx_q.push_back('{data: mon_bits[8:1], start_b: mon_bits[0],
                                     stop_b: mon_bits[FB-1], par_b: mon_bits[9], t: mon_t});
                    mon_active = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic par_model(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return (^b) ^ parity_odd;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int i;
        tx_data  = b;
        tx_valid = 1'b1;
        i = 0;
        while (!tx_ready && i < 5000) begin
            tick();
            i++;
        end
        tick();
        tx_valid = 1'b0;
        exp_q.push_back({par_model(b), b});
    endtask

    task automatic wait_rx(input int n);
        int i;
        i = 0;
        while (rx_q.size() < n && i < 20000) begin
            tick();
            i++;
        end
        chk("rx_arrived", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_until(input int unsigned target);
        int i;
        i = 0;
        while (cyc < target && i < 20000) begin
            tick();
            i++;
        end
        chk("cycle_reached", 32'(cyc), 32'(target));
    endtask

    task automatic check_frame(input string tag);
        rx_t        r;
        logic [8:0] e;
        chk({tag, "_pending"}, 32'(exp_q.size() > 0 && rx_idx < rx_q.size()), 32'd1);
        if (exp_q.size() == 0 || rx_idx >= rx_q.size()) return;
        r = rx_q[rx_idx];
        rx_idx++;
        e = exp_q.pop_front();
        chk({tag, "_data"},  32'(r.data),    32'(e[7:0]));
        chk({tag, "_start"}, 32'(r.start_b), 32'd0);
        chk({tag, "_stop"},  32'(r.stop_b),  32'd1);
`ifdef UART_TX_PARITY_EN
        chk({tag, "_parity"}, 32'(r.par_b), 32'(e[8]));
`endif
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        int          base;
        int          i;

        reset    = 1'b0;
        div_cfg  = 16'd104;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_ser_tx",   32'(ser_tx),     32'd1);
        chk("rst_tx_ready", 32'(tx_ready),   32'd1);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_level",    32'(fifo_level), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // single byte 'A': latency and decode
        push_byte(8'h41);
        chk("a_line_at_push", 32'(ser_tx),     32'd1);
        chk("a_level_push",   32'(fifo_level), 32'd1);
        chk("a_busy_push",    32'(busy),       32'd1);
        tick();
        chk("a_start_latency", 32'(ser_tx),     32'd0);
        chk("a_level_popped",  32'(fifo_level), 32'd0);
        t0 = cyc;
        wait_rx(1);
        chk("a_start_time", 32'(rx_q[0].t), 32'(t0));
        check_frame("a");
        wait_until(t0 + FB * 106 - 1);
        chk("a_busy_last", 32'(busy), 32'd1);
        tick();
        chk("a_busy_fall", 32'(busy), 32'd0);

        // fill the FIFO behind a running frame, then hold 0x55 against a full FIFO
        base = rx_idx;
        push_byte(8'hA5);
        for (int b = 0; b < 8; b++) push_byte(8'(b));
        chk("fill_tx_ready", 32'(tx_ready),   32'd0);
        chk("fill_level",    32'(fifo_level), 32'd8);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        chk("hold_level", 32'(fifo_level), 32'd8);
        chk("hold_ready", 32'(tx_ready),   32'd0);
        i = 0;
        while (!tx_ready && i < 5000) begin
            tick();
            i++;
        end
        chk("hold_ready_back", 32'(tx_ready), 32'd1);
        tick();
        tx_valid = 1'b0;
        exp_q.push_back({par_model(8'h55), 8'h55});
        chk("hold_accept_level", 32'(fifo_level), 32'd8);
        chk("hold_accept_ready", 32'(tx_ready),   32'd0);
        wait_rx(base + 10);
        for (int k = 0; k < 10; k++) check_frame("burst");
        for (int k = 0; k < 9; k++)
            chk("burst_gap", 32'(rx_q[base+k+1].t - rx_q[base+k].t), 32'(FB * 106));
        wait_until(rx_q[base+9].t + FB * 106 - 1);
        chk("burst_busy_last", 32'(busy), 32'd1);
        tick();
        chk("burst_busy_fall", 32'(busy),        32'd0);
        chk("burst_no_extra",  32'(rx_q.size()), 32'(rx_idx));

        // divisor change mid-frame applies to the next frame only
        base = rx_idx;
        push_byte(8'h96);
        t1 = cyc + 1;
        push_byte(8'h3A);
        wait_until(t1 + 300);
        div_cfg = 16'd10;
        wait_rx(base + 2);
        check_frame("div_old");
        check_frame("div_new");
        chk("div_first_len", 32'(rx_q[base+1].t - rx_q[base].t), 32'(FB * 106));
        wait_until(rx_q[base+1].t + FB * 12 - 1);
        chk("div_busy_last", 32'(busy), 32'd1);
        tick();
        chk("div_busy_fall", 32'(busy), 32'd0);

        // zero divisor selects the default
        div_cfg = 16'd0;
        push_byte(8'hC3);
        t1 = cyc + 1;
        wait_rx(base + 3);
        chk("div0_start_time", 32'(rx_q[base+2].t), 32'(t1));
        check_frame("div0");
        wait_until(t1 + FB * 106 - 1);
        chk("div0_busy_last", 32'(busy), 32'd1);
        tick();
        chk("div0_busy_fall", 32'(busy), 32'd0);

        // reset during data bit 1 of 0x3C with three bytes queued
        div_cfg = 16'd10;
        push_byte(8'h3C);
        t1 = cyc + 1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        wait_until(t1 + 30);
        chk("abort_pre_line",  32'(ser_tx),     32'd0);
        chk("abort_pre_level", 32'(fifo_level), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_line_high", 32'(ser_tx),     32'd1);
        chk("abort_level",     32'(fifo_level), 32'd0);
        chk("abort_ready",     32'(tx_ready),   32'd1);
        chk("abort_busy",      32'(busy),       32'd0);
        repeat (2) tick();
        reset = 1'b1;
        exp_q.delete();
        repeat (400) tick();
        chk("abort_no_frames", 32'(rx_q.size()), 32'(rx_idx));
        chk("abort_idle_line", 32'(ser_tx),      32'd1);
        chk("abort_idle_busy", 32'(busy),        32'd0);

`ifdef UART_TX_PARITY_EN
        // even then odd parity on 0x07
        base = rx_idx;
        parity_odd = 1'b0;
        push_byte(8'h07);
        wait_rx(base + 1);
        check_frame("par_even");
        wait_until(rx_q[base].t + FB * 12 + 5);
        parity_odd = 1'b1;
        push_byte(8'h07);
        t1 = cyc + 1;
        wait_until(t1 + 10 * 12 - 1);
        chk("par_odd_bit_line", 32'(ser_tx), 32'd0);
        tick();
        chk("par_odd_stop_edge", 32'(ser_tx), 32'd1);
        wait_rx(base + 2);
        check_frame("par_odd");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
